// File: rtl/st7920_link_arbiter_if.sv
// rtl/st7920_link_arbiter_if.sv - requester handshake and ST7920 serial link bundle
//
// Purpose: groups the two requester command channels and the serial link
// outputs of st7920_link_arbiter into one interface.
// Ports (signals):
//   req0_valid/req0_cmd[9:0]/req0_lock -> arbiter, req0_ready <- arbiter
//   req1_valid/req1_cmd[9:0]/req1_lock -> arbiter, req1_ready <- arbiter
//   lcd_clk, lcd_data, lcd_cs           serial link to E, R/W, RS pins
//   busy, grant[1:0]                    arbiter status
// Modports: master = requester/observer side, slave = arbiter side.

interface st7920_link_arbiter_if;
  logic       req0_valid;
  logic [9:0] req0_cmd;
  logic       req0_lock;
  logic       req0_ready;
  logic       req1_valid;
  logic [9:0] req1_cmd;
  logic       req1_lock;
  logic       req1_ready;
  logic       lcd_clk;
  logic       lcd_data;
  logic       lcd_cs;
  logic       busy;
  logic [1:0] grant;

  modport master (
    output req0_valid, req0_cmd, req0_lock,
    output req1_valid, req1_cmd, req1_lock,
    input  req0_ready, req1_ready,
    input  lcd_clk, lcd_data, lcd_cs, busy, grant
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_lock,
    input  req1_valid, req1_cmd, req1_lock,
    output req0_ready, req1_ready,
    output lcd_clk, lcd_data, lcd_cs, busy, grant
  );
endinterface

// File: rtl/st7920_link_arbiter.sv
// rtl/st7920_link_arbiter.sv - two-requester round-robin arbiter and ST7920 serialiser
//
// Purpose: shares one ST7920 serial link between a framebuffer sequencer
// (req0) and a host overlay (req1). Round-robin with bus locking so a
// multi-command burst is never split; each granted 10-bit command is sent
// as a 24-bit serial frame followed by the controller execution gap.
// Ports:
//   sys_clk  system clock
//   sys_rst  asynchronous active-high reset
//   bus      st7920_link_arbiter_if.slave (requests, readies, link, status)

module st7920_link_arbiter #(
  parameter int CLK_DIV          = 4,
  parameter int GAP_CYCLES       = 32,
  parameter int CLEAR_GAP_CYCLES = 4096
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  st7920_link_arbiter_if.slave        bus
);

  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GMAX = (GAP_CYCLES > CLEAR_GAP_CYCLES) ? GAP_CYCLES : CLEAR_GAP_CYCLES;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0] CLR_LOAD   = GW'(CLEAR_GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_phase;
  logic [4:0]      r_bit;
  logic [GW-1:0]   r_gap;
  logic [22:0]     r_shift;
  logic            r_is_clear;
  logic            r_last;
  logic [1:0]      r_owner;
  logic [1:0]      r_grant;
  logic            r_lcd_clk;
  logic            r_lcd_data;
  logic            r_lcd_cs;
  logic            r_busy;

  logic [1:0]      w_valid;
  logic [1:0]      w_owner_held;
  logic [1:0]      w_ready;
  logic            w_accept;
  logic            w_win;
  logic [9:0]      w_cmd;
  logic            w_lock;
  logic [23:0]     w_frame;

  assign w_valid = {bus.req1_valid, bus.req0_valid};

  // The owner keeps the bus while it still asserts lock or has a command
  // waiting; once both drop, it is released and normal arbitration applies
  // in the very same cycle.
  assign w_owner_held = r_owner & {bus.req1_lock | bus.req1_valid,
                                   bus.req0_lock | bus.req0_valid};

  always_comb begin
    w_ready = 2'b00;
    if (r_state == S_IDLE && !sys_rst) begin
      if (w_owner_held[0]) begin
        w_ready[0] = w_valid[0];
      end else if (w_owner_held[1]) begin
        w_ready[1] = w_valid[1];
      end else if (w_valid == 2'b11) begin
        w_ready = r_last ? 2'b01 : 2'b10;
      end else begin
        w_ready = w_valid;
      end
    end
  end

  assign w_accept = |w_ready;
  assign w_win    = w_ready[1];
  assign w_cmd    = w_win ? bus.req1_cmd  : bus.req0_cmd;
  assign w_lock   = w_win ? bus.req1_lock : bus.req0_lock;

  // Serial frame: sync, RW, RS, 0, high nibble, 0000, low nibble, 0000.
  assign w_frame = {5'b11111, w_cmd[8], w_cmd[9], 1'b0,
                    w_cmd[7:4], 4'b0000, w_cmd[3:0], 4'b0000};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit      <= '0;
      r_gap      <= '0;
      r_shift    <= '0;
      r_is_clear <= 1'b0;
      r_last     <= 1'b1;
      r_owner    <= 2'b00;
      r_grant    <= 2'b00;
      r_lcd_clk  <= 1'b0;
      r_lcd_data <= 1'b0;
      r_lcd_cs   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_owner <= w_owner_held;
          r_grant <= w_owner_held;
          if (w_accept) begin
            r_state    <= S_SHIFT;
            r_busy     <= 1'b1;
            r_shift    <= w_frame[22:0];
            r_lcd_data <= w_frame[23];
            r_lcd_cs   <= 1'b1;
            r_lcd_clk  <= 1'b0;
            r_phase    <= '0;
            r_bit      <= '0;
            r_is_clear <= (w_cmd == 10'h001);
            r_last     <= w_win;
            r_grant    <= w_ready;
            r_owner    <= w_lock ? w_ready : 2'b00;
          end
        end

        S_SHIFT: begin
          if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
            if (!r_lcd_clk) begin
              r_lcd_clk <= 1'b1;
            end else if (r_bit == 5'd23) begin
              r_lcd_clk  <= 1'b0;
              r_lcd_cs   <= 1'b0;
              r_lcd_data <= 1'b0;
              r_state    <= S_GAP;
              r_gap      <= r_is_clear ? CLR_LOAD : GAP_LOAD;
            end else begin
              // Data only moves on the falling edge so it is stable at the
              // LCD's rising-edge sample point.
              r_lcd_clk  <= 1'b0;
              r_bit      <= r_bit + 5'd1;
              r_lcd_data <= r_shift[22];
              r_shift    <= {r_shift[21:0], 1'b0};
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_grant <= r_owner;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.lcd_clk    = r_lcd_clk;
  assign bus.lcd_data   = r_lcd_data;
  assign bus.lcd_cs     = r_lcd_cs;
  assign bus.busy       = r_busy;
  assign bus.grant      = r_grant;

endmodule

// File: tb/tb_st7920_link_arbiter.sv
// tb/tb_st7920_link_arbiter.sv - self-checking bench for st7920_link_arbiter

module tb_st7920_link_arbiter;
  localparam int CD = 2;
  localparam int GP = 4;
  localparam int CG = 20;
  localparam int FL = 48 * CD;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  st7920_link_arbiter_if bus();

  st7920_link_arbiter #(
    .CLK_DIV(CD),
    .GAP_CYCLES(GP),
    .CLEAR_GAP_CYCLES(CG)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_total = 0;

  int edge_n = 0;
  int m_acc = -1;
  int m_gap = 0;
  int m_owner = -1;
  int m_last = 1;
  int m_win = 0;
  logic [23:0] m_frame = '0;

  int acc_edge[$];
  int acc_who[$];

  logic [23:0] cap = '0;
  int cap_n = 0;
  int cs_len = 0;
  logic [23:0] last_bits = '0;
  int last_bits_n = 0;
  int last_cs_len = 0;
  logic prev_clk = 1'b0;
  logic prev_cs = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic logic [23:0] frame_of(input logic [9:0] c);
    return {5'b11111, c[8], c[9], 1'b0, c[7:4], 4'b0000, c[3:0], 4'b0000};
  endfunction

  // One clock cycle: compare at the falling edge, advance model at the rising edge.
  task automatic cycle();
    int d, own, w;
    bit act;
    logic [1:0] v, lk, er;
    logic e_clk, e_cs, e_data, e_busy;
    logic [1:0] e_grant;
    logic [9:0] wc;
    @(negedge sys_clk);
    v  = {bus.req1_valid, bus.req0_valid};
    lk = {bus.req1_lock, bus.req0_lock};
    d = edge_n - m_acc;
    act = (m_acc >= 0) && (d < FL + m_gap);
    own = m_owner;
    w = -1;
    er = 2'b00;
    wc = '0;
    if (act) begin
      e_cs    = (d < FL);
      e_clk   = e_cs && ((d % (2 * CD)) >= CD);
      e_data  = e_cs ? m_frame[23 - d / (2 * CD)] : 1'b0;
      e_busy  = 1'b1;
      e_grant = 2'(1 << m_win);
    end else begin
      e_cs = 1'b0; e_clk = 1'b0; e_data = 1'b0; e_busy = 1'b0;
      e_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
      if (!sys_rst) begin
        if (own >= 0 && !lk[own] && !v[own]) own = -1;
        if (own >= 0) w = v[own] ? own : -1;
        else if (v == 2'b11) w = 1 - m_last;
        else if (v[0]) w = 0;
        else if (v[1]) w = 1;
        if (w >= 0) begin
          er[w] = 1'b1;
          wc = (w == 1) ? bus.req1_cmd : bus.req0_cmd;
        end
      end
    end
    chk("lcd_cs", int'(bus.lcd_cs), int'(e_cs));
    chk("lcd_clk", int'(bus.lcd_clk), int'(e_clk));
    chk("lcd_data", int'(bus.lcd_data), int'(e_data));
    chk("busy", int'(bus.busy), int'(e_busy));
    chk("grant", int'(bus.grant), int'(e_grant));
    chk("req0_ready", int'(bus.req0_ready), int'(er[0]));
    chk("req1_ready", int'(bus.req1_ready), int'(er[1]));
    if (bus.lcd_cs && !prev_cs) begin cap = '0; cap_n = 0; cs_len = 0; end
    if (bus.lcd_cs) cs_len++;
    if (bus.lcd_clk && !prev_clk) begin cap = {cap[22:0], bus.lcd_data}; cap_n++; end
    if (!bus.lcd_cs && prev_cs) begin last_bits = cap; last_bits_n = cap_n; last_cs_len = cs_len; end
    prev_cs = bus.lcd_cs;
    prev_clk = bus.lcd_clk;
    @(posedge sys_clk);
    edge_n++;
    if (!act && !sys_rst) begin
      m_owner = own;
      if (w >= 0) begin
        m_acc = edge_n;
        m_frame = frame_of(wc);
        m_gap = (wc == 10'h001) ? CG : GP;
        m_last = w;
        m_win = w;
        m_owner = lk[w] ? w : -1;
        acc_edge.push_back(edge_n);
        acc_who.push_back(w);
      end
    end
    #1;
  endtask

  task automatic wait_acc(input int budget, input string name);
    int n0;
    n0 = acc_edge.size();
    for (int i = 0; i < budget && acc_edge.size() == n0; i++) cycle();
    chk({name, "_accepted"}, int'(acc_edge.size() > n0), 1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    chk("rst_cs", int'(bus.lcd_cs), 0);
    chk("rst_clk", int'(bus.lcd_clk), 0);
    chk("rst_data", int'(bus.lcd_data), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_grant", int'(bus.grant), 0);
    m_acc = -1;
    m_owner = -1;
    m_last = 1;
    repeat (2) cycle();
    sys_rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [9:0] c, input logic l);
    if (r == 0) begin bus.req0_valid = v; bus.req0_cmd = c; bus.req0_lock = l; end
    else begin bus.req1_valid = v; bus.req1_cmd = c; bus.req1_lock = l; end
  endtask

  initial begin
    int n0, k;
    set_req(0, 1'b0, 10'h000, 1'b0);
    set_req(1, 1'b0, 10'h000, 1'b0);
    #2;
    do_reset();
    repeat (3) cycle();

    // Single command from req0
    set_req(0, 1'b1, 10'h030, 1'b0);
    wait_acc(50, "s_single");
    set_req(0, 1'b0, 10'h030, 1'b0);
    repeat (120) cycle();
    chk("single_bits", int'(last_bits), int'(24'hF83000));
    chk("single_nbits", last_bits_n, 24);
    chk("single_cs_len", last_cs_len, 96);

    // Both requesters continuously valid, no lock
    do_reset();
    set_req(0, 1'b1, 10'h030, 1'b0);
    set_req(1, 1'b1, 10'h0C1, 1'b0);
    n0 = acc_edge.size();
    repeat (4) wait_acc(150, "s_rr");
    set_req(0, 1'b0, 10'h030, 1'b0);
    set_req(1, 1'b0, 10'h0C1, 1'b0);
    if (acc_edge.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) chk("rr_winner", acc_who[n0 + i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr_interval", acc_edge[n0 + i] - acc_edge[n0 + i - 1], 101);
    end else chk("rr_count", acc_edge.size() - n0, 4);

    // Display Clear from req1, req0 raised during the long gap
    set_req(1, 1'b1, 10'h001, 1'b0);
    wait_acc(150, "s_clear");
    set_req(1, 1'b0, 10'h001, 1'b0);
    n0 = acc_edge.size();
    repeat (100) cycle();
    set_req(0, 1'b1, 10'h055, 1'b0);
    wait_acc(50, "s_after_clear");
    set_req(0, 1'b0, 10'h055, 1'b0);
    chk("clear_interval", acc_edge[acc_edge.size() - 1] - acc_edge[n0 - 1], 117);
    chk("clear_winner", acc_who[acc_edge.size() - 1], 0);
    repeat (130) cycle();

    // Locked burst of three from req0 while req1 waits
    do_reset();
    set_req(1, 1'b1, 10'h0C1, 1'b0);
    set_req(0, 1'b1, 10'h030, 1'b1);
    n0 = acc_edge.size();
    wait_acc(150, "s_lock1");
    set_req(0, 1'b1, 10'h031, 1'b1);
    wait_acc(150, "s_lock2");
    set_req(0, 1'b1, 10'h032, 1'b0);
    wait_acc(150, "s_lock3");
    set_req(0, 1'b0, 10'h032, 1'b0);
    wait_acc(150, "s_lock4");
    set_req(1, 1'b0, 10'h0C1, 1'b0);
    if (acc_edge.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) chk("lock_winner", acc_who[n0 + i], (i == 3) ? 1 : 0);
      chk("lock_req1_interval", acc_edge[n0 + 3] - acc_edge[n0 + 2], 101);
    end else chk("lock_count", acc_edge.size() - n0, 4);
    repeat (110) cycle();

    // Reset at bit 10 of a locked frame; pending req1 wins after release
    set_req(0, 1'b1, 10'h030, 1'b1);
    set_req(1, 1'b1, 10'h0C1, 1'b0);
    wait_acc(150, "s_rst_frame");
    chk("rst_frame_winner", acc_who[acc_edge.size() - 1], 0);
    set_req(0, 1'b0, 10'h030, 1'b0);
    k = 0;
    while (edge_n - m_acc < 40 && k < 200) begin cycle(); k++; end
    chk("rst_frame_reached_bit10", edge_n - m_acc, 40);
    do_reset();
    wait_acc(20, "s_after_rst");
    chk("after_rst_winner", acc_who[acc_edge.size() - 1], 1);

    // req1 sends 2A5 (rs=1, rw=0)
    set_req(1, 1'b1, 10'h2A5, 1'b0);
    wait_acc(150, "s_2a5");
    set_req(1, 1'b0, 10'h2A5, 1'b0);
    repeat (120) cycle();
    chk("rs_bits", int'(last_bits), int'(24'hFAA050));
    chk("rs_nbits", last_bits_n, 24);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      set_req(0, 1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 10'h001 : 10'($urandom),
              1'($urandom_range(0, 3) == 0));
      set_req(1, 1'($urandom_range(0, 2) != 0),
              ($urandom_range(0, 7) == 0) ? 10'h001 : 10'($urandom),
              1'($urandom_range(0, 4) == 0));
      cycle();
    end
    set_req(0, 1'b0, 10'h000, 1'b0);
    set_req(1, 1'b0, 10'h000, 1'b0);
    repeat (200) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
